// File: rtl/bg_probe_reader_if.sv
// vga_if: pixel stream bundle shared along the background drawing chain.
// Carries raster timing (counters, syncs, blanking) plus the 12-bit colour.
// Modport "out" belongs to the stage driving the bundle. Modport "in" belongs
// to the stage consuming it.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/bg_probe_reader.sv
// bg_probe_reader: inline tap on the background pixel stream.
// The block counts platform-coloured pixels in two probe strips:
//   - a foot strip directly below the character's feet;
//   - a head strip directly above the character's head.
// Once per frame, on the rising edge of vblnk, it publishes the contact results.
// The stream itself passes through with a single register stage.
// Optional build macro: PROBE_OVERLAY_EN paints both strips magenta on the output stream.
module bg_probe_reader #(
  parameter int          PROBE_W    = 16,
  parameter int          PROBE_H    = 4,
  parameter int          CHAR_H     = 64,
  parameter int          HIT_THRESH = 8,
  parameter logic [11:0] MATCH_RGB  = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  vga_if.in           in,
  vga_if.out          out,
  input  logic [10:0] probe_x,
  input  logic [10:0] probe_y,
  output logic        on_floor,
  output logic        head_hit,
  output logic [15:0] floor_cnt,
  output logic        result_valid
);

  typedef enum logic [1:0] {S_SYNC, S_WAIT, S_COUNT, S_PUBLISH} state_t;

  localparam logic signed [11:0] PW_S = 12'(PROBE_W);
  localparam logic signed [11:0] PH_S = 12'(PROBE_H);
  localparam logic signed [11:0] CH_S = 12'(CHAR_H);
  localparam logic [15:0]        THR  = 16'(HIT_THRESH);

  state_t      state_q, state_d;
  logic        vblnk_q;
  logic [10:0] px_q, py_q;
  logic [15:0] foot_cnt, head_cnt;

  logic latch_coords, clear_cnt, count_en, publish;
  logic frame_edge, active;
  logic in_cols, in_foot, in_head, foot_match, head_match;
  logic signed [11:0] h_s, v_s, x_lo, x_hi, foot_lo, foot_hi, head_lo, head_hi;
  logic [11:0] rgb_next;

  assign frame_edge = in.vblnk & ~vblnk_q;
  assign active     = ~in.hblnk & ~in.vblnk;

  // Strip geometry in 12-bit signed. A head strip above row 0 becomes negative
  // and can never match, so clipping falls out of the comparisons.
  assign h_s     = $signed({1'b0, in.hcount});
  assign v_s     = $signed({1'b0, in.vcount});
  assign x_lo    = $signed({1'b0, px_q});
  assign x_hi    = x_lo + PW_S - 12'sd1;
  assign foot_lo = $signed({1'b0, py_q}) + 12'sd1;
  assign foot_hi = $signed({1'b0, py_q}) + PH_S;
  assign head_lo = $signed({1'b0, py_q}) - CH_S - PH_S;
  assign head_hi = $signed({1'b0, py_q}) - CH_S - 12'sd1;

  assign in_cols = (h_s >= x_lo) && (h_s <= x_hi);
  assign in_foot = active && in_cols && (v_s >= foot_lo) && (v_s <= foot_hi);
  assign in_head = active && in_cols && (v_s >= head_lo) && (v_s <= head_hi);

  // Matching always looks at the incoming colour, never at the overlaid one.
  assign foot_match = count_en && in_foot && (in.rgb == MATCH_RGB);
  assign head_match = count_en && in_head && (in.rgb == MATCH_RGB);

`ifdef PROBE_OVERLAY_EN
  assign rgb_next = (in_foot || in_head) ? 12'hF0F : in.rgb;
`else
  assign rgb_next = in.rgb;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every flop in the
    // same edge then sees pre-edge values, whatever order the blocks run in.
    if (!rst_n) state_q <= S_SYNC;
    else        state_q <= state_d;
  end

  // Next-state and control strobes for the frame sequencer.
  always_comb begin
    // NOTE: every output gets a default before the case. A path that leaves one
    // unassigned would otherwise infer a latch.
    state_d      = state_q;
    latch_coords = 1'b0;
    clear_cnt    = 1'b0;
    count_en     = 1'b0;
    publish      = 1'b0;
    unique case (state_q)
      S_SYNC: begin
        // First edge after reset only arms the counters. The partial frame is dropped.
        if (frame_edge) begin
          latch_coords = 1'b1;
          clear_cnt    = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!in.vblnk) state_d = S_COUNT;
      end
      S_COUNT: begin
        count_en = 1'b1;
        if (frame_edge) begin
          publish      = 1'b1;
          latch_coords = 1'b1;
          clear_cnt    = 1'b1;
          state_d      = S_PUBLISH;
        end
      end
      S_PUBLISH: state_d = S_WAIT;
      default:   state_d = S_SYNC;
    endcase
  end

  // Frame-edge history and per-frame coordinate latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vblnk_q <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      vblnk_q <= in.vblnk;
      if (latch_coords) begin
        px_q <= probe_x;
        py_q <= probe_y;
      end
    end
  end

  // Saturating match counters. The clear on a publish edge lands after their
  // values have been captured into the result registers.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_cnt) begin
      foot_cnt <= '0;
      head_cnt <= '0;
    end else begin
      if (foot_match && (foot_cnt != 16'hFFFF)) foot_cnt <= foot_cnt + 16'd1;
      if (head_match && (head_cnt != 16'hFFFF)) head_cnt <= head_cnt + 16'd1;
    end
  end

  // Published results. They hold until the next publish, with a one-cycle valid strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      floor_cnt    <= '0;
      on_floor     <= 1'b0;
      head_hit     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= publish;
      if (publish) begin
        floor_cnt <= foot_cnt;
        on_floor  <= (foot_cnt >= THR);
        head_hit  <= (head_cnt >= THR);
      end
    end
  end

  // One-stage registered pass-through of the stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= in.hcount;
      out.vcount <= in.vcount;
      out.hsync  <= in.hsync;
      out.vsync  <= in.vsync;
      out.hblnk  <= in.hblnk;
      out.vblnk  <= in.vblnk;
      out.rgb    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_bg_probe_reader.sv
// Testbench for bg_probe_reader.
// The stimulus is a sparse raster: each frame sends only the rows and columns
// around the latched probe, plus a few extra rows.
// A behavioural model tallies the strip pixels that were sent and predicts every publish.
// A per-cycle scoreboard checks the pass-through and the result outputs.
module tb_bg_probe_reader;
  localparam int          PROBE_W    = 16;
  localparam int          PROBE_H    = 4;
  localparam int          CHAR_H     = 64;
  localparam int          HIT_THRESH = 8;
  localparam logic [11:0] BLACK      = 12'h000;
  localparam logic [11:0] GRAY       = 12'h888;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] probe_x = '0;
  logic [10:0] probe_y = '0;
  logic        on_floor, head_hit, result_valid;
  logic [15:0] floor_cnt;

  vga_if in_bus();
  vga_if out_bus();

  bg_probe_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (in_bus),
    .out          (out_bus),
    .probe_x      (probe_x),
    .probe_y      (probe_y),
    .on_floor     (on_floor),
    .head_hit     (head_hit),
    .floor_cnt    (floor_cnt),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   edges   = 0;           // vblnk rising edges seen since reset
  bit   prev_vb = 1'b0;
  int   lat_x = 0, lat_y = 0;  // coordinates governing the frame being counted
  int   acc_foot = 0, acc_head = 0;
  logic [37:0] exp_out   = '0;
  logic        exp_valid = 1'b0, exp_on = 1'b0, exp_head = 1'b0;
  logic [15:0] exp_floor = '0;
  bit   mon_en = 1'b0;
  int   pulses = 0;

  // Stimulus controls
  bit rnd_mode = 1'b0;
  int chg_row = -1, chg_x = 0, chg_y = 0, rst_row = -1;

  // Standard background: gray, with two black platforms spanning columns 100..649.
  function automatic logic [11:0] bg_rgb(input int x, input int y);
    if (x >= 100 && x <= 649 && ((y >= 596 && y <= 610) || (y >= 216 && y <= 224)))
      return BLACK;
    return GRAY;
  endfunction

  function automatic bit foot_px(input int x, input int y);
    return x >= lat_x && x < lat_x + PROBE_W && y > lat_y && y <= lat_y + PROBE_H;
  endfunction

  function automatic bit head_px(input int x, input int y);
    return x >= lat_x && x < lat_x + PROBE_W &&
           y >= lat_y - CHAR_H - PROBE_H && y < lat_y - CHAR_H;
  endfunction

  // Applies the frame rules to the cycle the DUT has just sampled.
  task automatic model_step();
    if (!rst_n) begin
      edges = 0; prev_vb = 1'b0; lat_x = 0; lat_y = 0;
      acc_foot = 0; acc_head = 0;
      exp_out = '0; exp_valid = 1'b0; exp_on = 1'b0; exp_head = 1'b0; exp_floor = '0;
    end else begin
      exp_out = {in_bus.hcount, in_bus.vcount, in_bus.hsync, in_bus.vsync,
                 in_bus.hblnk, in_bus.vblnk, in_bus.rgb};
      exp_valid = 1'b0;
      if (edges >= 1 && !in_bus.hblnk && !in_bus.vblnk && in_bus.rgb == BLACK) begin
        if (foot_px(int'(in_bus.hcount), int'(in_bus.vcount))) acc_foot++;
        if (head_px(int'(in_bus.hcount), int'(in_bus.vcount))) acc_head++;
      end
      if (in_bus.vblnk && !prev_vb) begin
        if (edges >= 1) begin
          exp_valid = 1'b1;
          exp_floor = 16'(acc_foot);
          exp_on    = (acc_foot >= HIT_THRESH);
          exp_head  = (acc_head >= HIT_THRESH);
        end
        edges++;
        lat_x = int'(probe_x);
        lat_y = int'(probe_y);
        acc_foot = 0; acc_head = 0;
      end
      prev_vb = in_bus.vblnk;
    end
  endtask

  // Per-cycle scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("passthru", {out_bus.hcount, out_bus.vcount, out_bus.hsync, out_bus.vsync,
                         out_bus.hblnk, out_bus.vblnk, out_bus.rgb}, exp_out);
      check("results", {result_valid, on_floor, head_hit, floor_cnt},
                       {exp_valid, exp_on, exp_head, exp_floor});
      if (result_valid) pulses++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int h, input int v, input bit hb, input bit vb, input logic [11:0] rgb);
    in_bus.hcount = 11'(h);
    in_bus.vcount = 11'(v);
    in_bus.hblnk  = hb;
    in_bus.vblnk  = vb;
    in_bus.rgb    = rgb;
    in_bus.hsync  = 1'($urandom_range(0, 1));
    in_bus.vsync  = 1'($urandom_range(0, 1));
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [11:0] pix(input int x, input int y);
    if (!rnd_mode) return bg_rgb(x, y);
    if ($urandom_range(0, 1) == 1) return BLACK;
    return 12'($urandom);
  endfunction

  // Sends the rows around the latched strips (plus extras), then a vblank.
  // Each line opens with horizontal blanking.
  task automatic frame_std(input int extra_row);
    int rows[$];
    int c_lo, c_hi;
    for (int r = lat_y - CHAR_H - PROBE_H - 1; r <= lat_y - CHAR_H; r++)
      if (r >= 0 && r <= 767) rows.push_back(r);
    for (int r = lat_y - 1; r <= lat_y + PROBE_H + 1; r++)
      if (r >= 0 && r <= 767) rows.push_back(r);
    if (extra_row >= 0) rows.push_back(extra_row);
    if (rnd_mode) repeat (2) rows.push_back(int'($urandom_range(0, 767)));
    rows.sort();
    c_lo = (lat_x > 3) ? lat_x - 3 : 0;
    c_hi = lat_x + PROBE_W + 2;
    if (c_hi > 1023) c_hi = 1023;
    foreach (rows[i]) begin
      if (rows[i] == chg_row) begin
        probe_x = 11'(chg_x);
        probe_y = 11'(chg_y);
      end
      tick(1100, rows[i], 1'b1, 1'b0, GRAY);
      tick(1101, rows[i], 1'b1, 1'b0, GRAY);
      for (int c = c_lo; c <= c_hi; c++) tick(c, rows[i], 1'b0, 1'b0, pix(c, rows[i]));
      if (rows[i] == rst_row) begin
        rst_n = 1'b0;
        tick(1102, rows[i], 1'b0, 1'b0, BLACK);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_clear", {on_floor, head_hit, floor_cnt, result_valid,
                            out_bus.hcount, out_bus.vcount, out_bus.rgb}, 64'd0);
      end
    end
    for (int k = 0; k < 3; k++) tick(0, 780, 1'b1, 1'b1, GRAY);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation ran past its time limit, expected completion");
    $fatal(1);
  end

  initial begin
    int rx, ry, er, p0;
    rst_n = 1'b0;
    tick(0, 0, 1'b1, 1'b0, GRAY);
    mon_en = 1'b1;
    tick(0, 0, 1'b1, 1'b0, GRAY);
    rst_n = 1'b1;

    // Three frames over the platform. The first edge must stay silent.
    probe_x = 11'd200; probe_y = 11'd595;
    frame_std(-1);
    check("first_edge_quiet", pulses, 0);
    frame_std(-1);
    check("f2_floor_cnt", floor_cnt, 64);
    check("f2_on_floor", on_floor, 1);
    probe_y = 11'd500;
    frame_std(-1);
    check("f3_floor_cnt", floor_cnt, 64);
    check("f3_pulses", pulses, 2);

    // Gray under the feet.
    probe_y = 11'd289;
    frame_std(-1);
    check("gray_floor_cnt", floor_cnt, 0);
    check("gray_flags", {on_floor, head_hit}, 0);

    // Head strip against the upper platform.
    probe_x = 11'd648; probe_y = 11'd595;
    frame_std(-1);
    check("head_hit", head_hit, 1);
    check("head_on_floor", on_floor, 0);

    // Right edge of the platform.
    probe_x = 11'd649;
    frame_std(-1);
    check("edge648_cnt", floor_cnt, 8);
    check("edge648_on", on_floor, 1);
    probe_x = 11'd200;
    frame_std(-1);
    check("edge649_cnt", floor_cnt, 4);
    check("edge649_on", on_floor, 0);

    // Mid-frame coordinate change applies only from the next frame.
    chg_row = 300; chg_x = 200; chg_y = 500;
    frame_std(300);
    chg_row = -1;
    check("midchg_cnt", floor_cnt, 64);
    probe_y = 11'd595;
    frame_std(-1);
    check("midchg_next", floor_cnt, 0);

    // Reset in the middle of a frame. The next publish comes at the second edge.
    rst_row = 400;
    frame_std(400);
    rst_row = -1;
    p0 = pulses;
    check("post_rst_edge1", pulses - p0, 0);
    frame_std(-1);
    check("post_rst_edge2", pulses - p0, 1);
    check("post_rst_cnt", floor_cnt, 64);

    // Randomized frames: random colours, probes, and mid-frame probe changes.
    rnd_mode = 1'b1;
    for (int f = 0; f < 36; f++) begin
      rx = int'($urandom_range(0, 1023));
      case ($urandom_range(0, 3))
        0:       ry = int'($urandom_range(0, 80));
        1:       ry = int'($urandom_range(700, 767));
        default: ry = int'($urandom_range(0, 767));
      endcase
      probe_x = 11'(rx);
      probe_y = 11'(ry);
      er = int'($urandom_range(0, 767));
      chg_row = er;
      chg_x = int'($urandom_range(0, 1023));
      chg_y = int'($urandom_range(0, 767));
      frame_std(er);
    end
    chg_row = -1;
    tick(1100, 0, 1'b1, 1'b0, GRAY);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
